pll_lock_manager: RTL and testbench

Sequencing controller for the board PLL (10 MHz reference in, 25/125 MHz out). It drives the PLL reset, waits for and qualifies `locked`, and holds the downstream clock-domain reset until lock has been continuously stable. On loss of lock or a software request, it re-runs the PLL reset sequence and counts lock-loss events. It runs on the free-running reference clock, so it keeps operating while the PLL outputs are absent.

---
 rtl/pll_lock_manager.sv | 142 ++++++++++++++
 tb/tb_pll_lock_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_manager.sv
// PLL reset/lock sequencer on the free-running reference clock: drives pll_rst,
// qualifies a synchronized locked, gates the downstream reset and counts lock losses.
module pll_lock_manager #(
  parameter int unsigned RST_HOLD_CYCLES     = 100,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             sw_relock,
  input  logic             clear_stat,
  output logic             pll_rst,
  output logic             ready,
  output logic             sys_rst,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic             timeout_err,
  output logic [1:0]       state
);

  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1, locked_s;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [STAB_W-1:0] stab_cnt, stab_d, stab_inc;
  logic [TMO_W-1:0]  tmo_cnt, tmo_d, tmo_inc;
  logic              loss, tmo_hit;

  assign state    = state_q;
  assign stab_inc = stab_cnt + 1'b1;
  // The timeout counter parks at its last value so a late lock in WAIT_LOCK
  // still times out on the following STABLE cycle.
  assign tmo_inc  = (tmo_cnt >= TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    stab_d  = stab_cnt;
    tmo_d   = tmo_cnt;
    loss    = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
          tmo_d   = '0;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        tmo_d = tmo_inc;
        if (locked_s) begin
          state_d = STABLE;
          stab_d  = '0;
        end else if (tmo_cnt >= TMO_LAST) begin
          state_d = RESET_PLL;
          tmo_hit = 1'b1;
          tmo_d   = '0;
        end
      end
      STABLE: begin
        tmo_d = tmo_inc;
        // The WAIT_LOCK exit sample counts as the first qualified cycle, so
        // completion is judged on the incremented value.
        if (locked_s && (stab_inc >= STAB_LAST)) begin
          state_d = RUN;
          stab_d  = '0;
        end else if (tmo_cnt >= TMO_LAST) begin
          state_d = RESET_PLL;
          tmo_hit = 1'b1;
          tmo_d   = '0;
          stab_d  = '0;
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else begin
          stab_d = stab_inc;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          loss    = 1'b1;
        end else if (sw_relock) begin
          state_d = RESET_PLL;
        end
      end
      default: state_d = RESET_PLL;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1         <= 1'b0;
      locked_s      <= 1'b0;
      state_q       <= RESET_PLL;
      hold_cnt      <= '0;
      stab_cnt      <= '0;
      tmo_cnt       <= '0;
      pll_rst       <= 1'b1;
      ready         <= 1'b0;
      sys_rst       <= 1'b1;
      lock_loss_cnt <= '0;
      timeout_err   <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
      state_q  <= state_d;
      hold_cnt <= hold_d;
      stab_cnt <= stab_d;
      tmo_cnt  <= tmo_d;
      pll_rst  <= (state_d == RESET_PLL);
      ready    <= (state_d == RUN);
      sys_rst  <= (state_d != RUN);
      if (clear_stat) begin
        lock_loss_cnt <= '0;
        timeout_err   <= 1'b0;
      end else begin
        if (loss && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + 1'b1;
        if (tmo_hit) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_manager.sv
// Directed scenarios followed by random traffic, checked every cycle against a
// streak/elapsed-time model of the lock qualification rules.
module tb_pll_lock_manager;

  localparam int unsigned H = 4;
  localparam int unsigned L = 8;
  localparam int unsigned T = 50;
  localparam int unsigned W = 4;

  logic         refclk = 1'b0;
  logic         rst, locked, sw_relock, clear_stat;
  logic         pll_rst, ready, sys_rst, timeout_err;
  logic [W-1:0] lock_loss_cnt;
  logic [1:0]   state;

  pll_lock_manager #(
    .RST_HOLD_CYCLES(H),
    .LOCK_STABLE_CYCLES(L),
    .LOCK_TIMEOUT_CYCLES(T),
    .CNT_W(W)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .locked(locked),
    .sw_relock(sw_relock),
    .clear_stat(clear_stat),
    .pll_rst(pll_rst),
    .ready(ready),
    .sys_rst(sys_rst),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_err(timeout_err),
    .state(state)
  );

  always #5 refclk = ~refclk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Model: mode 0 = PLL held in reset, 1 = qualifying lock, 2 = running.
  int m_mode, m_hold, m_elapsed, m_streak, m_cnt, m_err;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_mode = 0; m_hold = 0; m_elapsed = 0; m_streak = 0;
    m_cnt = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge();
    bit ls, lost, tmo;
    ls = m_s2; lost = 0; tmo = 0;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        m_hold++;
        if (m_hold == H) begin m_mode = 1; m_elapsed = 0; m_streak = 0; end
      end
      1: begin
        m_elapsed++;
        if (m_streak == 0) begin
          if (ls) m_streak = 1;
          else if (m_elapsed >= T) tmo = 1;
        end else begin
          if (ls && (m_streak + 1 == L)) m_mode = 2;
          else if (m_elapsed >= T) tmo = 1;
          else if (!ls) m_streak = 0;
          else m_streak++;
        end
        if (tmo) begin m_mode = 0; m_hold = 0; end
      end
      default: begin
        if (!ls) begin lost = 1; m_mode = 0; m_hold = 0; end
        else if (sw_relock) begin m_mode = 0; m_hold = 0; end
      end
    endcase
    if (clear_stat) begin
      m_cnt = 0; m_err = 0;
    end else begin
      if (lost && m_cnt < (1 << W) - 1) m_cnt++;
      if (tmo) m_err = 1;
    end
    m_s2 = m_s1;
    m_s1 = locked;
  endtask

  function automatic int exp_state();
    if (m_mode == 0) return 0;
    if (m_mode == 2) return 3;
    return (m_streak == 0) ? 1 : 2;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @edge %0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",         32'(state),         32'(exp_state()));
    chk("pll_rst",       32'(pll_rst),       32'(m_mode == 0));
    chk("ready",         32'(ready),         32'(m_mode == 2));
    chk("sys_rst",       32'(sys_rst),       32'(m_mode != 2));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_cnt));
    chk("timeout_err",   32'(timeout_err),   32'(m_err));
  endtask

  task automatic step();
    @(posedge refclk);
    edge_n++;
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts rst away from any edge and checks the outputs before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_until_ready(string tag, int budget);
    for (int i = 0; i < budget && m_mode != 2; i++) step();
    chk(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int rel, k, rise, fall, n, run_left;
    rst = 1'b1; locked = 1'b0; sw_relock = 1'b0; clear_stat = 1'b0;
    model_reset();
    #2;

    // 1: reset release with locked low, lock at cycle 10
    do_reset();
    rel = edge_n; fall = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pll_rst === 1'b0 && fall < 0) fall = edge_n;
    end
    chk("t1_pll_rst_hold", 32'(fall - rel), 32'(H));
    locked = 1'b1;
    k = edge_n + 1; rise = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ready === 1'b1 && rise < 0) rise = edge_n;
    end
    chk("t1_ready_latency", 32'(rise - k), 32'(L + 1));

    // 2: no lock at all -> repeated timeouts
    do_reset();
    locked = 1'b0;
    for (int i = 0; i < 130; i++) step();
    chk("t2_timeout_err", 32'(timeout_err), 32'd1);
    chk("t2_cnt_zero", 32'(lock_loss_cnt), 32'd0);

    // 3: lock loss in RUN for 20 cycles, then re-lock
    locked = 1'b1;
    run_until_ready("t3_first_ready", 200);
    for (int i = 0; i < 5; i++) step();
    locked = 1'b0;
    for (int i = 0; i < 20; i++) step();
    locked = 1'b1;
    run_until_ready("t3_relock_ready", 200);
    chk("t3_cnt", 32'(lock_loss_cnt), 32'd1);

    // 4: glitch during STABLE at stable count 5
    sw_relock = 1'b1; step(); sw_relock = 1'b0;
    for (int i = 0; i < 60 && m_streak != 4; i++) step();
    locked = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_back_to_wait", 32'(state), 32'd1);
    locked = 1'b1;
    k = edge_n + 1; rise = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ready === 1'b1 && rise < 0) rise = edge_n;
    end
    chk("t4_requalify_latency", 32'(rise - k), 32'(L + 1));

    // 5: saturation, then clear colliding with an 18th loss
    clear_stat = 1'b1; step(); clear_stat = 1'b0;
    for (int j = 0; j < 17; j++) begin
      locked = 1'b1;
      run_until_ready("t5_ready", 200);
      locked = 1'b0;
      step(); step(); step();
    end
    chk("t5_saturate", 32'(lock_loss_cnt), 32'd15);
    locked = 1'b1;
    run_until_ready("t5_ready18", 200);
    locked = 1'b0;
    step(); step();
    clear_stat = 1'b1; step(); clear_stat = 1'b0;
    chk("t5_clear_wins", 32'(lock_loss_cnt), 32'd0);
    chk("t5_loss_taken", 32'(state), 32'd0);

    // 6: sw_relock in RUN keeps the count; rst during WAIT_LOCK
    locked = 1'b1;
    run_until_ready("t6_ready_a", 200);
    locked = 1'b0; step(); step(); step(); locked = 1'b1;
    run_until_ready("t6_ready_b", 200);
    sw_relock = 1'b1; step(); sw_relock = 1'b0;
    n = (pll_rst === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pll_rst === 1'b1) n++;
    end
    chk("t6_pll_rst_len", 32'(n), 32'(H));
    chk("t6_cnt_kept", 32'(lock_loss_cnt), 32'd1);
    locked = 1'b0;
    sw_relock = 1'b1; step(); sw_relock = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t6_in_wait", 32'(state), 32'd1);
    do_reset();

    // Random traffic
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        locked   = ~locked;
        run_left = locked ? $urandom_range(1, 70) : $urandom_range(1, 30);
      end
      run_left--;
      sw_relock  = ($urandom_range(0, 29) == 0);
      clear_stat = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        sw_relock = 1'b0; clear_stat = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end
    sw_relock = 1'b0; clear_stat = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
